johnson_phase_sequencer: RTL and testbench

Controller that wraps an N-stage Johnson (twisted-ring) state register and sequences it as a 2N-phase timing generator. It runs a programmed number of full rounds on command, supports pause and abort, and emits a one-hot phase strobe bus. Downstream datapath stages use it to time multi-phase operations. It replaces free-running Johnson counters wherever bounded, controllable phase sequences are needed.

---
 rtl/johnson_phase_sequencer.sv | 103 ++++++++++
 tb/tb_johnson_phase_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_sequencer.sv
// johnson_phase_sequencer: bounded, pausable, abortable 2N-phase Johnson timing generator
module johnson_phase_sequencer #(
  parameter int N = 4,
  parameter int CW = 8,
  localparam int IW = $clog2(2 * N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   rounds,
  input  logic            pause,
  input  logic            abort,
  output logic [N-1:0]    q,
  output logic [2*N-1:0]  phase,
  output logic [IW-1:0]   phase_idx,
  output logic [CW-1:0]   rounds_left,
  output logic            busy,
  output logic            done,
  output logic            aborted
);
  localparam int PW = 2 * N;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_n;
  logic [N-1:0] q_n;
  logic [IW-1:0] idx_n;
  logic [CW-1:0] rl_n;
  logic [PW-1:0] phase_n;
  logic done_n, ab_n, legal;
  function automatic logic [N-1:0] jcode(input int k);
    logic [N-1:0] c;
    for (int i = 0; i < N; i++) c[i] = (i < k) && (i + N >= k);
    return c;
  endfunction
  always_comb begin
    legal = 1'b0;
    for (int k = 0; k < PW; k++) legal = legal | (q == jcode(k));
  end
  always_comb begin
    state_n = state;
    q_n = q;
    idx_n = phase_idx;
    rl_n = rounds_left;
    done_n = 1'b0;
    ab_n = 1'b0;
    if (state == IDLE) begin
      q_n = '0;
      idx_n = '0;
      if (start && !abort) begin
        if (rounds != '0) begin
          state_n = RUN;
          rl_n = rounds;
        end else done_n = 1'b1;
      end
    end else if (abort) begin
      state_n = IDLE;
      q_n = '0;
      idx_n = '0;
      rl_n = '0;
      ab_n = 1'b1;
    end else if (!legal) begin
      // corrupted ring: resynchronise to phase 0 without leaving the sequence
      q_n = '0;
      idx_n = '0;
    end else if (state == HOLD) begin
      state_n = pause ? HOLD : RUN;
    end else if (pause) begin
      state_n = HOLD;
    end else if (phase_idx == IW'(PW - 1)) begin
      q_n = '0;
      idx_n = '0;
      if (rounds_left > CW'(1)) rl_n = rounds_left - CW'(1);
      else begin
        state_n = IDLE;
        rl_n = '0;
        done_n = 1'b1;
      end
    end else begin
      q_n = {q[N-2:0], ~q[N-1]};
      idx_n = phase_idx + IW'(1);
    end
    phase_n = (state_n != IDLE) ? PW'(1) << idx_n : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      q <= '0;
      phase <= '0;
      phase_idx <= '0;
      rounds_left <= '0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= state_n;
      q <= q_n;
      phase <= phase_n;
      phase_idx <= idx_n;
      rounds_left <= rl_n;
      done <= done_n;
      aborted <= ab_n;
    end
  end
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// tb_johnson_phase_sequencer: directed scenario tests for the Johnson phase sequencer (N=4)
module tb_johnson_phase_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [7:0] rounds = '0;
  logic pause = 1'b0;
  logic abort = 1'b0;
  logic [3:0] q;
  logic [7:0] phase;
  logic [2:0] phase_idx;
  logic [7:0] rounds_left;
  logic busy, done, aborted;
  int checks = 0;
  int failures = 0;
  logic [3:0] jq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hf, 4'he, 4'hc, 4'h8};

  johnson_phase_sequencer #(.N(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .rounds(rounds), .pause(pause), .abort(abort),
    .q(q), .phase(phase), .phase_idx(phase_idx), .rounds_left(rounds_left),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic kick(input logic [7:0] r);
    rounds = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({q, phase, phase_idx, rounds_left, busy, done, aborted} !== '0) begin
      failures++;
      $display("FAIL reset_state got q=%h phase=%h idx=%0d rl=%0d busy=%b done=%b ab=%b want all zero",
               q, phase, phase_idx, rounds_left, busy, done, aborted);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    kick(8'd1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (busy !== 1'b1 || q !== jq[k] || phase !== (8'h01 << k) || phase_idx !== 3'(k) || done !== 1'b0) begin
        failures++;
        $display("FAIL single_step%0d got busy=%b q=%b phase=%h idx=%0d done=%b want busy=1 q=%b phase=%h idx=%0d done=0",
                 k, busy, q, phase, phase_idx, done, jq[k], 8'h01 << k, k);
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || q !== 4'h0 || phase !== 8'h00) begin
      failures++;
      $display("FAIL single_done got busy=%b done=%b q=%b phase=%h want busy=0 done=1 q=0000 phase=00",
               busy, done, q, phase);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse got done=%b want 0", done);
    end
  endtask

  task automatic test_multi;
    int bcnt = 0, dcnt = 0, nr = 0;
    logic [7:0] seen [3] = '{8'h0, 8'h0, 8'h0};
    kick(8'd3);
    for (int s = 0; s < 40; s++) begin
      if (busy) bcnt++;
      if (busy && phase_idx == 3'd0 && nr < 3) begin
        seen[nr] = rounds_left;
        nr++;
      end
      if (done) dcnt++;
      @(negedge clk);
    end
    checks++;
    if (bcnt != 24) begin
      failures++;
      $display("FAIL multi_busy_cycles got %0d want 24", bcnt);
    end
    checks++;
    if (nr != 3 || seen[0] !== 8'd3 || seen[1] !== 8'd2 || seen[2] !== 8'd1) begin
      failures++;
      $display("FAIL multi_rounds_left got n=%0d %0d,%0d,%0d want 3,2,1", nr, seen[0], seen[1], seen[2]);
    end
    checks++;
    if (dcnt != 1) begin
      failures++;
      $display("FAIL multi_done_count got %0d want 1", dcnt);
    end
  endtask

  task automatic test_pause;
    int bcnt = 3;
    kick(8'd1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q !== 4'h3) begin
      failures++;
      $display("FAIL pause_setup got q=%b want 0011", q);
    end
    pause = 1'b1;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      if (h == 3) pause = 1'b0;
      bcnt++;
      checks++;
      if (q !== 4'h3 || busy !== 1'b1 || rounds_left !== 8'd1) begin
        failures++;
        $display("FAIL pause_hold%0d got q=%b busy=%b rl=%0d want q=0011 busy=1 rl=1", h, q, busy, rounds_left);
      end
    end
    @(negedge clk);
    checks++;
    if (q !== 4'h7) begin
      failures++;
      $display("FAIL pause_resume got q=%b want 0111", q);
    end
    for (int s = 0; s < 20 && busy; s++) begin
      bcnt++;
      @(negedge clk);
    end
    checks++;
    if (bcnt != 13) begin
      failures++;
      $display("FAIL pause_busy_cycles got %0d want 13", bcnt);
    end
  endtask

  task automatic test_abort;
    int dcnt = 0;
    kick(8'd3);
    for (int s = 0; s < 13; s++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    checks++;
    if (phase_idx !== 3'd5 || rounds_left !== 8'd2) begin
      failures++;
      $display("FAIL abort_setup got idx=%0d rl=%0d want idx=5 rl=2", phase_idx, rounds_left);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || q !== 4'h0 || rounds_left !== 8'd0 || aborted !== 1'b1 || done !== 1'b0 || phase !== 8'h00) begin
      failures++;
      $display("FAIL abort_effect got busy=%b q=%b rl=%0d ab=%b done=%b phase=%h want 0,0000,0,1,0,00",
               busy, q, rounds_left, aborted, done, phase);
    end
    if (done) dcnt++;
    @(negedge clk);
    if (done) dcnt++;
    checks++;
    if (aborted !== 1'b0 || dcnt != 0) begin
      failures++;
      $display("FAIL abort_pulse got ab=%b done_count=%0d want ab=0 done_count=0", aborted, dcnt);
    end
  endtask

  task automatic test_zero_and_ignore;
    kick(8'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_rounds got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_rounds_after got done=%b busy=%b want 0,0", done, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (aborted !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_abort got ab=%b busy=%b want 0,0", aborted, busy);
    end
    kick(8'd2);
    @(negedge clk);
    kick(8'd5);
    checks++;
    if (rounds_left !== 8'd2 || busy !== 1'b1 || phase_idx !== 3'd2) begin
      failures++;
      $display("FAIL start_while_busy got rl=%0d busy=%b idx=%0d want rl=2 busy=1 idx=2", rounds_left, busy, phase_idx);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    kick(8'd2);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({q, phase, phase_idx, rounds_left, busy, done, aborted} !== '0) begin
      failures++;
      $display("FAIL async_reset got q=%h phase=%h idx=%0d rl=%0d busy=%b done=%b ab=%b want all zero",
               q, phase, phase_idx, rounds_left, busy, done, aborted);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_release got done=%b ab=%b busy=%b want 0,0,0", done, aborted, busy);
    end
    test_single;
  endtask

  initial begin
    test_reset;
    test_single;
    test_multi;
    test_pause;
    test_abort;
    test_zero_and_ignore;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
